// File: rtl/mc_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_cpu_ctrl
// Description : Multi-cycle CPU control FSM (fetch/decode/exec/mem/wb/trap)
//               with bus-wait timeout, sticky trap and performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_cpu_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 255,
    parameter int                PERF_W   = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    output logic              if_req,
    output logic [ADDR_W-1:0] if_addr,
    input  logic              if_ack,
    input  logic [31:0]       if_rdata,
    input  logic              dec_illegal,
    input  logic              dec_is_mem,
    input  logic              dec_is_store,
    input  logic              dec_rf_we,
    input  logic [ADDR_W-1:0] npc_in,
    output logic              bus_req,
    output logic              bus_we,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic [31:0]       mdr,
    output logic              wb_en,
    output logic              trap,
    output logic [2:0]        trap_cause,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [15:0] c_WAIT_LAST = 16'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_if_req;
    logic              r_bus_req;
    logic              r_bus_we;
    logic              r_wb_en;
    logic [15:0]       r_wait;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [31:0]       r_mdr;
    logic              r_trap;
    logic [2:0]        r_cause;
    logic [PERF_W-1:0] r_cycle;
    logic [PERF_W-1:0] r_instret;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state   <= S_FETCH;
            r_if_req  <= 1'b0;
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_wb_en   <= 1'b0;
            r_wait    <= 16'd0;
            r_pc      <= RESET_PC;
            r_ir      <= 32'h0000_0013;
            r_mdr     <= 32'h0000_0000;
            r_trap    <= 1'b0;
            r_cause   <= 3'd0;
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_cycle <= r_cycle + PERF_W'(1);
            case (r_state)
                S_FETCH: begin
                    // After reset the request is raised one edge into FETCH.
                    if (!r_if_req) begin
                        r_if_req <= 1'b1;
                        r_wait   <= 16'd0;
                    end else if (if_ack) begin
                        r_ir     <= if_rdata;
                        r_if_req <= 1'b0;
                        r_state  <= S_DECODE;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_if_req <= 1'b0;
                        r_trap   <= 1'b1;
                        r_cause  <= 3'd2;
                        r_state  <= S_TRAP;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        r_trap  <= 1'b1;
                        r_cause <= 3'd1;
                        r_state <= S_TRAP;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (dec_is_mem) begin
                        r_bus_req <= 1'b1;
                        r_bus_we  <= dec_is_store;
                        r_wait    <= 16'd0;
                        r_state   <= S_MEM;
                    end else begin
                        r_wb_en <= dec_rf_we;
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus_ack) begin
                        if (!r_bus_we) begin
                            r_mdr <= bus_rdata;
                        end
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_wb_en   <= dec_rf_we;
                        r_state   <= S_WB;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_trap    <= 1'b1;
                        r_cause   <= 3'd3;
                        r_state   <= S_TRAP;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                S_WB: begin
                    r_wb_en <= 1'b0;
                    if (npc_in[1:0] != 2'b00) begin
                        r_trap  <= 1'b1;
                        r_cause <= 3'd4;
                        r_state <= S_TRAP;
                    end else begin
                        r_pc      <= npc_in;
                        r_instret <= r_instret + PERF_W'(1);
                        r_if_req  <= 1'b1;
                        r_wait    <= 16'd0;
                        r_state   <= S_FETCH;
                    end
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign if_req      = r_if_req;
    assign if_addr     = r_pc;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign wb_en       = r_wb_en;
    assign pc          = r_pc;
    assign ir          = r_ir;
    assign mdr         = r_mdr;
    assign trap        = r_trap;
    assign trap_cause  = r_cause;
    assign cycle_cnt   = r_cycle;
    assign instret_cnt = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_mc_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_cpu_ctrl
// Description : Directed self-checking bench for mc_cpu_ctrl with a
//               timeline-level reference model and per-cycle compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_cpu_ctrl;

    localparam int          c_TO  = 4;
    localparam logic [31:0] c_RPC = 32'h0000_0000;

    // Expected control vector {trap, wb_en, bus_we, bus_req, if_req}
    localparam logic [4:0] c_V_IDLE = 5'b00000;
    localparam logic [4:0] c_V_IF   = 5'b00001;
    localparam logic [4:0] c_V_LD   = 5'b00010;
    localparam logic [4:0] c_V_ST   = 5'b00110;
    localparam logic [4:0] c_V_WB   = 5'b01000;
    localparam logic [4:0] c_V_TRAP = 5'b10000;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack = 1'b0;
    logic [31:0] if_rdata = '0;
    logic        dec_illegal = 1'b0, dec_is_mem = 1'b0, dec_is_store = 1'b0, dec_rf_we = 1'b0;
    logic [31:0] npc_in = '0;
    logic        bus_req, bus_we;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [31:0] pc, ir, mdr;
    logic        wb_en, trap;
    logic [2:0]  trap_cause;
    logic [31:0] cycle_cnt, instret_cnt;

    mc_cpu_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (c_RPC),
        .TIMEOUT  (c_TO),
        .PERF_W   (32)
    ) u_dut (
        .cpu_clk      (cpu_clk),
        .cpu_rst      (cpu_rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ack       (if_ack),
        .if_rdata     (if_rdata),
        .dec_illegal  (dec_illegal),
        .dec_is_mem   (dec_is_mem),
        .dec_is_store (dec_is_store),
        .dec_rf_we    (dec_rf_we),
        .npc_in       (npc_in),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .pc           (pc),
        .ir           (ir),
        .mdr          (mdr),
        .wb_en        (wb_en),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [4:0]  exp_q[$];
    int unsigned m_cycle = 0;
    int unsigned m_instret;
    logic [31:0] m_pc, m_ir, m_mdr;
    logic        m_trap;
    logic [2:0]  m_cause;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // Model: cycle counter counts every edge seen with reset low.
    always @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) m_cycle = 0;
        else         m_cycle++;
    end

    always @(negedge cpu_clk) begin
        logic [4:0] v;
        if (!cpu_rst) begin
            chk("cycle_cnt", cycle_cnt, m_cycle);
            chk("req_exclusive", {if_req, bus_req, wb_en} inside {3'b000, 3'b100, 3'b010, 3'b001}, 1'b1);
            if (if_req) chk("if_addr", if_addr, m_pc);
            if (exp_q.size() > 0) begin
                v = exp_q.pop_front();
                chk("ctl_vector", {trap, wb_en, bus_we, bus_req, if_req}, v);
            end
        end
    end

    task automatic check_state();
        chk("pc", pc, m_pc);
        chk("instret", instret_cnt, m_instret);
        chk("ir", ir, m_ir);
        chk("mdr", mdr, m_mdr);
        chk("trap", trap, m_trap);
        chk("trap_cause", trap_cause, m_cause);
    endtask

    task automatic finish_trap(input logic [2:0] cause);
        m_trap  = 1'b1;
        m_cause = cause;
        if_ack  = 1'b0;
        bus_ack = 1'b0;
        repeat (3) tick();
        check_state();
    endtask

    task automatic do_reset();
        if_ack = 1'b0; bus_ack = 1'b0;
        dec_illegal = 1'b0; dec_is_mem = 1'b0; dec_is_store = 1'b0; dec_rf_we = 1'b0;
        cpu_rst = 1'b1;
        #1;
        exp_q.delete();
        m_pc = c_RPC; m_ir = 32'h0000_0013; m_mdr = '0;
        m_instret = 0; m_trap = 1'b0; m_cause = 3'd0;
        chk("rst_if_req", if_req, 1'b0);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_wb_en", wb_en, 1'b0);
        chk("rst_cycle", cycle_cnt, 0);
        check_state();
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b0;
        tick();
        chk("if_req_after_rst", if_req, 1'b1);
        chk("if_addr_after_rst", if_addr, c_RPC);
    endtask

    // fw/mw: ack in request cycle fw+1 / mw+1; negative means never ack.
    task automatic run_instr(input int fw, input bit ill, input bit mem, input bit st,
                             input bit rfw, input int mw, input logic [31:0] word,
                             input logic [31:0] rd, input logic [31:0] npc, input bit noise);
        int nf, nm;
        nf = (fw < 0) ? c_TO : fw + 1;
        nm = (mw < 0) ? c_TO : mw + 1;
        dec_illegal = ill; dec_is_mem = mem; dec_is_store = st; dec_rf_we = rfw;
        npc_in = npc;
        repeat (nf) exp_q.push_back(c_V_IF);
        if (fw >= 0) begin
            exp_q.push_back(c_V_IDLE);
            if (!ill) begin
                exp_q.push_back(c_V_IDLE);
                if (mem) repeat (nm) exp_q.push_back(st ? c_V_ST : c_V_LD);
                if (!(mem && mw < 0)) exp_q.push_back(rfw ? c_V_WB : c_V_IDLE);
            end
        end
        if (fw < 0 || ill || (mem && mw < 0) || npc[1:0] != 2'b00)
            repeat (3) exp_q.push_back(c_V_TRAP);

        for (int i = 0; i < nf; i++) begin
            if_ack   = (i == fw);
            if_rdata = (i == fw) ? word : (32'hBAD0_0000 | i);
            tick();
        end
        if_ack   = noise;
        if_rdata = 32'hFFFF_FFFF;
        if (fw < 0) begin finish_trap(3'd2); return; end
        m_ir = word;
        tick();
        if (ill) begin finish_trap(3'd1); return; end
        bus_ack = noise;
        tick();
        if (mem) begin
            for (int i = 0; i < nm; i++) begin
                bus_ack   = (i == mw);
                bus_rdata = (i == mw) ? rd : (32'h5555_0000 | i);
                tick();
            end
            bus_ack = 1'b0;
            if (mw < 0) begin finish_trap(3'd3); return; end
            if (!st) m_mdr = rd;
        end
        bus_ack = noise;
        tick();
        if_ack = 1'b0; bus_ack = 1'b0;
        if (npc[1:0] != 2'b00) begin finish_trap(3'd4); return; end
        m_pc = npc;
        m_instret++;
        check_state();
    endtask

    initial begin
        #2;
        do_reset();

        run_instr(0, 0, 0, 0, 1, 0, 32'h0020_8033, '0, 32'h0000_0004, 0);
        chk("alu_pc_lit", pc, 32'h4);
        chk("alu_instret_lit", instret_cnt, 1);
        chk("alu_cpi_lit", cycle_cnt, 5);

        run_instr(0, 0, 1, 0, 1, 3, 32'h0000_2083, 32'hDEAD_BEEF, 32'h0000_0008, 0);
        chk("load_mdr_lit", mdr, 32'hDEAD_BEEF);
        chk("load_cycles_lit", cycle_cnt, 13);

        run_instr(2, 0, 1, 1, 0, 1, 32'h0011_2023, 32'h1234_5678, 32'h0000_0100, 1);
        chk("store_mdr_hold_lit", mdr, 32'hDEAD_BEEF);
        chk("store_cycles_lit", cycle_cnt, 21);

        run_instr(3, 0, 0, 0, 0, 0, 32'h0000_0013, '0, 32'h0000_0104, 1);
        chk("late_ack_notrap_lit", trap, 1'b0);
        chk("late_ack_cycles_lit", cycle_cnt, 28);

        run_instr(0, 1, 0, 0, 1, 0, 32'hFFFF_FFFF, '0, 32'h0000_0108, 1);
        chk("illegal_cause_lit", trap_cause, 3'd1);
        chk("illegal_pc_lit", pc, 32'h0000_0104);
        chk("illegal_cycle_lit", cycle_cnt, 33);

        do_reset();
        run_instr(0, 0, 0, 0, 1, 0, 32'h0000_0033, '0, 32'h0000_0006, 0);
        chk("misalign_cause_lit", trap_cause, 3'd4);
        chk("misalign_instret_lit", instret_cnt, 0);

        do_reset();
        run_instr(-1, 0, 0, 0, 0, 0, '0, '0, 32'h4, 0);
        chk("fetch_to_cause_lit", trap_cause, 3'd2);

        do_reset();
        run_instr(0, 0, 1, 0, 1, -1, 32'h0000_2083, '0, 32'h4, 0);
        chk("mem_to_cause_lit", trap_cause, 3'd3);

        do_reset();
        run_instr(0, 0, 0, 0, 1, 0, 32'h0000_0033, '0, 32'h0000_0004, 0);
        dec_is_mem = 1'b1; dec_is_store = 1'b0; dec_rf_we = 1'b1; npc_in = 32'h8;
        exp_q.push_back(c_V_IF);
        repeat (2) exp_q.push_back(c_V_IDLE);
        repeat (2) exp_q.push_back(c_V_LD);
        if_ack = 1'b1; if_rdata = 32'h0000_2083;
        tick();
        if_ack = 1'b0; m_ir = 32'h0000_2083;
        repeat (4) tick();
        chk("bus_req_before_rst", bus_req, 1'b1);
        do_reset();
        chk("mid_mem_rst_pc_lit", pc, c_RPC);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_cpu_ctrl.md
MC_CPU_CTRL -- requirements
Module: mc_cpu_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, sets the width of PC and bus addresses.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, sets the PC value after reset.
REQ-003 Parameter TIMEOUT, default 255, sets the bus-wait cycles before trap; legal range 1..65535.
REQ-004 Parameter PERF_W, default 32, sets the width of the cycle and instret counters.
REQ-005 cpu_clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 cpu_rst  in  1  asynchronous, active-high reset.
REQ-007 if_req  out  1  instruction fetch request; if_addr  out  ADDR_W  = pc while if_req.
REQ-008 if_ack  in  1  fetch complete; if_rdata  in  32  instruction word, valid with if_ack.
REQ-009 dec_illegal, dec_is_mem, dec_is_store, dec_rf_we  in  1 each  decoder flags for the current ir.
REQ-010 npc_in  in  ADDR_W  next PC from the external NPC unit, sampled in WB.
REQ-011 bus_req  out  1  data bus request; bus_we  out  1  store (1) / load (0).
REQ-012 bus_ack  in  1  data transfer complete; bus_rdata  in  32  load data, valid with bus_ack.
REQ-013 pc  out  ADDR_W; ir  out  32; mdr  out  32 latched load data.
REQ-014 wb_en  out  1  register-file write strobe, one cycle.
REQ-015 trap  out  1 sticky; trap_cause  out  3.
REQ-016 cycle_cnt and instret_cnt  out  PERF_W each.

Function
REQ-017 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-018 FETCH: if_req=1. On if_ack, ir<=if_rdata and the next state is DECODE. An ack in the first cycle of the request SHALL be accepted.
REQ-019 DECODE: one cycle. If dec_illegal=1, go to TRAP with cause 1; otherwise go to EXEC.
REQ-020 EXEC: one cycle. If dec_is_mem=1, go to MEM; otherwise go to WB.
REQ-021 MEM: bus_req=1 and bus_we=dec_is_store. On bus_ack, mdr<=bus_rdata (loads only; mdr holds on stores) and the next state is WB.
REQ-022 WB: wb_en=dec_rf_we for exactly this cycle. If npc_in[1:0]!=0, go to TRAP with cause 4 and leave pc unchanged. Otherwise pc<=npc_in, instret_cnt+1, and the next state is FETCH.
REQ-023 Minimum CPI SHALL be 4 for non-memory instructions (FETCH 1, DECODE, EXEC, WB) and 5 for memory instructions.
REQ-024 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle the request is held without an ack.
REQ-025 If no ack arrives by the TIMEOUT-th request cycle, the next state SHALL be TRAP with cause 2 (fetch) or 3 (mem). An ack in that same cycle wins over the timeout.
REQ-026 if_ack outside FETCH and bus_ack outside MEM SHALL be ignored.
REQ-027 if_req, bus_req and wb_en SHALL never be asserted in the same cycle.
REQ-028 TRAP: trap=1 and all requests and wb_en are 0. TRAP is held until reset; pc holds the faulting instruction's address.
REQ-029 cycle_cnt SHALL increment every cycle out of reset, including in TRAP, and wrap modulo 2^PERF_W.
REQ-030 instret_cnt SHALL wrap modulo 2^PERF_W.
REQ-031 trap_cause encoding: 0 none, 1 illegal, 2 fetch timeout, 3 mem timeout, 4 misaligned npc.

Reset
REQ-032 While cpu_rst=1, the block SHALL immediately set: state FETCH, pc=RESET_PC, ir=32'h0000_0013, mdr=0, counters 0, trap=0, trap_cause=0.
REQ-033 Reset asserted mid-MEM or mid-FETCH SHALL drop bus_req/if_req in the same cycle, with no wb_en and no instret increment.
REQ-034 After release, if_req=1 with if_addr=RESET_PC on the first clock edge.

Verification
REQ-035 ALU instruction, if_ack immediate, dec_rf_we=1, npc_in=pc+4 -> wb_en pulses in cycle 4, pc=4, instret=1.
REQ-036 Load, bus_ack after 3 waits with bus_rdata=32'hDEADBEEF -> mdr=32'hDEADBEEF, wb_en 1 cycle, 8 cycles total.
REQ-037 TIMEOUT=4, if_ack never -> trap=1, cause 2 after 4 request cycles; if_ack in the 4th cycle instead -> DECODE, no trap.
REQ-038 dec_illegal=1 -> TRAP after DECODE, cause 1, pc unchanged, cycle_cnt still counting.
REQ-039 npc_in=32'h0000_0006 in WB -> cause 4, pc not updated, instret unchanged.
REQ-040 Reset pulse during MEM wait -> bus_req=0 at once, pc=RESET_PC, counters 0, fetch restarts.
